// File: rtl/axi3_regbank.sv
// Register bank behind the AXI3 slave bridge's req/ack bus: ID, W1C interrupt pending, control and status words.
// Optional MASK register at 0x008 when AXI3_REGBANK_IRQMASK_EN is defined.
module axi3_regbank #(
  parameter int              ADDR     = 32,
  parameter int              DATA     = 32,
  parameter int              NCTL     = 8,
  parameter int              NSTAT    = 8,
  parameter int              NIRQ     = 8,
  parameter logic [DATA-1:0] CTLRESET = '0,
  parameter logic [DATA-1:0] IDWORD   = 32'h52454742
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR-1:0]       busaddr,
  input  logic [DATA-1:0]       buswdata,
  input  logic [DATA/8-1:0]     buswstrb,
  input  logic                  buswr,
  input  logic                  busreq,
  output logic                  busack,
  output logic                  buserr,
  output logic [DATA-1:0]       busrdata,
  output logic [NCTL*DATA-1:0]  ctl,
  input  logic [NSTAT*DATA-1:0] stat,
  input  logic [NIRQ-1:0]       irqin,
  output logic                  irq
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t          r_state, w_next;
  logic [DATA-1:0] r_ctl [NCTL];
  logic [NIRQ-1:0] r_pend, r_irq_d;
  logic            r_irq, r_err;
  logic [DATA-1:0] r_rdata;

  logic [11:0]     w_off;
  logic [5:0]      w_idx;
  logic            w_aligned, w_hit_id, w_hit_pend, w_hit_mask, w_hit_ctl, w_hit_stat;
  logic            w_err, w_fire, w_we;
  logic [DATA-1:0] w_bmask, w_wbits, w_ctl_rd, w_stat_rd, w_mask_rd, w_rdata;
  logic [NIRQ-1:0] w_rise, w_clr, w_irq_src;
  logic            w_unused;

  // Base decode happens upstream; only the low 12 address bits matter here.
  assign w_unused  = &{1'b0, busaddr[ADDR-1:12]};
  assign w_off     = busaddr[11:0];
  assign w_idx     = w_off[7:2];
  assign w_aligned = (w_off[1:0] == 2'b00);

  assign w_hit_id   = (w_off == 12'h000);
  assign w_hit_pend = (w_off == 12'h004);
  assign w_hit_ctl  = (w_off[11:8] == 4'h1) && ({1'b0, w_idx} < 7'(NCTL));
  assign w_hit_stat = (w_off[11:8] == 4'h2) && ({1'b0, w_idx} < 7'(NSTAT));
`ifdef AXI3_REGBANK_IRQMASK_EN
  assign w_hit_mask = (w_off == 12'h008);
`else
  assign w_hit_mask = 1'b0;
`endif

  assign w_err  = !w_aligned
               || !(w_hit_id || w_hit_pend || w_hit_mask || w_hit_ctl || w_hit_stat)
               || (buswr && (w_hit_id || w_hit_stat));
  assign w_fire = (r_state == IDLE) && busreq;
  assign w_we   = w_fire && buswr && !w_err;

  always_comb begin
    for (int k = 0; k < DATA/8; k++) w_bmask[8*k +: 8] = {8{buswstrb[k]}};
  end
  assign w_wbits = buswdata & w_bmask;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_ctl_rd  = '0;
    w_stat_rd = '0;
    for (int i = 0; i < NCTL; i++)  if (6'(i) == w_idx) w_ctl_rd  = r_ctl[i];
    for (int i = 0; i < NSTAT; i++) if (6'(i) == w_idx) w_stat_rd = stat[DATA*i +: DATA];
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit_id)        w_rdata = IDWORD;
    else if (w_hit_pend) w_rdata = DATA'(r_pend);
    else if (w_hit_mask) w_rdata = w_mask_rd;
    else if (w_hit_ctl)  w_rdata = w_ctl_rd;
    else if (w_hit_stat) w_rdata = w_stat_rd;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (busreq) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_fire && w_err;
      r_rdata <= (w_fire && !w_err && !buswr) ? w_rdata : '0;
    end
  end

  // NOTE: the control bank is plain flops with a defined reset value, so every entry is reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCTL; i++) r_ctl[i] <= CTLRESET;
    end else begin
      for (int i = 0; i < NCTL; i++)
        if (w_we && w_hit_ctl && (6'(i) == w_idx))
          r_ctl[i] <= (r_ctl[i] & ~w_bmask) | w_wbits;
    end
  end

  // A same-cycle edge wins over a W1C clear so no edge is ever lost.
  assign w_rise = irqin & ~r_irq_d;
  assign w_clr  = (w_we && w_hit_pend) ? w_wbits[NIRQ-1:0] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend  <= '0;
      r_irq_d <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      r_irq_d <= irqin;
      r_irq   <= |w_irq_src;
    end
  end

`ifdef AXI3_REGBANK_IRQMASK_EN
  logic [NIRQ-1:0] r_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_mask <= '0;
    else if (w_we && w_hit_mask)
      r_mask <= (r_mask & ~w_bmask[NIRQ-1:0]) | w_wbits[NIRQ-1:0];
  end

  assign w_mask_rd = DATA'(r_mask);
  assign w_irq_src = r_pend & r_mask;
`else
  assign w_mask_rd = '0;
  assign w_irq_src = r_pend;
`endif

  for (genvar g = 0; g < NCTL; g++) begin : g_ctl
    assign ctl[DATA*g +: DATA] = r_ctl[g];
  end

  assign busack   = (r_state == RESP);
  assign buserr   = r_err;
  assign busrdata = r_rdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_axi3_regbank.sv
// Self-checking bench for axi3_regbank: scoreboarded bus transactions plus direct checks of ctl and irq.
module tb_axi3_regbank;

  localparam int          NCTL  = 8;
  localparam int          NSTAT = 8;
  localparam int          NIRQ  = 8;
  localparam logic [31:0] IDW   = 32'h52454742;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [31:0]          busaddr, buswdata;
  logic [3:0]           buswstrb;
  logic                 buswr, busreq;
  logic                 busack, buserr;
  logic [31:0]          busrdata;
  logic [NCTL*32-1:0]   ctl;
  logic [NSTAT*32-1:0]  stat;
  logic [NIRQ-1:0]      irqin;
  logic                 irq;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic ack_irq;

  axi3_regbank #(.NCTL(NCTL), .NSTAT(NSTAT), .NIRQ(NIRQ)) dut (
    .clk(clk), .resetn(resetn), .busaddr(busaddr), .buswdata(buswdata),
    .buswstrb(buswstrb), .buswr(buswr), .busreq(busreq), .busack(busack),
    .buserr(buserr), .busrdata(busrdata), .ctl(ctl), .stat(stat),
    .irqin(irqin), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] stat_word(input int i);
    return {8'h5A, 8'(i), 16'hC0DE};
  endfunction

  // Called at a negedge with the DUT idle; a busack still high here means a request would land in RESP.
  task automatic bus_start(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rd,
                           input string tag);
    n_vec++;
    if (busack !== 1'b0) begin
      n_miss++;
      $display("FAIL %s req_during_resp: busack=%b required 0", tag, busack);
    end
    busaddr  = addr;
    buswdata = data;
    buswstrb = strb;
    buswr    = wr;
    busreq   = 1'b1;
    sb.push_back('{exp_err, exp_rd, tag});
  endtask

  task automatic bus_finish;
    exp_t e;
    int   lat = 0;
    @(posedge clk);
    @(negedge clk);
    busreq = 1'b0;
    while (busack !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    ack_irq = irq;
    e = sb.pop_front();
    n_vec++;
    if (lat != 0) begin
      n_miss++;
      $display("FAIL %s latency: ack after %0d extra cycles, required 0", e.tag, lat);
    end
    n_vec++;
    if (buserr !== e.err) begin
      n_miss++;
      $display("FAIL %s buserr: got %b required %b", e.tag, buserr, e.err);
    end
    n_vec++;
    if (busrdata !== e.rdata) begin
      n_miss++;
      $display("FAIL %s busrdata: got %h required %h", e.tag, busrdata, e.rdata);
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr, input logic err, input logic [31:0] exp_rd, input string tag);
    bus_start(1'b0, addr, 32'h0, 4'hF, err, err ? 32'h0 : exp_rd, tag);
    bus_finish();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic err, input string tag);
    bus_start(1'b1, addr, data, strb, err, 32'h0, tag);
    bus_finish();
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busack !== 1'b0)   begin n_miss++; $display("FAIL rst_ack: got %b required 0", busack); end
    n_vec++; if (buserr !== 1'b0)   begin n_miss++; $display("FAIL rst_err: got %b required 0", buserr); end
    n_vec++; if (busrdata !== 32'h0) begin n_miss++; $display("FAIL rst_rdata: got %h required 0", busrdata); end
    n_vec++; if (ctl !== '0)        begin n_miss++; $display("FAIL rst_ctl: got %h required 0", ctl); end
    n_vec++; if (irq !== 1'b0)      begin n_miss++; $display("FAIL rst_irq: got %b required 0", irq); end
    resetn = 1'b1;
    @(negedge clk);
    rd(32'h000, 1'b0, IDW, "id");
    rd(32'h004, 1'b0, 32'h0, "pend_rst");
  endtask

  task automatic test_ctl_write;
    wr(32'h104, 32'hAABBCCDD, 4'b0101, 1'b0, "ctl1_wr");
    rd(32'h104, 1'b0, 32'h00BB00DD, "ctl1_rd");
    n_vec++;
    if (ctl[63:32] !== 32'h00BB00DD) begin
      n_miss++; $display("FAIL ctl1_port: got %h required 00bb00dd", ctl[63:32]);
    end
    wr(32'h104, 32'hFFFFFFFF, 4'b0000, 1'b0, "ctl1_nostrb");
    rd(32'h104, 1'b0, 32'h00BB00DD, "ctl1_keep");
    wr(32'h11C, 32'hCAFEF00D, 4'hF, 1'b0, "ctl7_wr");
    rd(32'hFFFF_F11C, 1'b0, 32'hCAFEF00D, "ctl7_hiaddr");
    n_vec++;
    if (ctl[255:224] !== 32'hCAFEF00D) begin
      n_miss++; $display("FAIL ctl7_port: got %h required cafef00d", ctl[255:224]);
    end
  endtask

  task automatic test_errors;
    rd(32'h102, 1'b1, 32'h0, "misalign_rd");
    wr(32'h106, 32'hFFFFFFFF, 4'hF, 1'b1, "misalign_wr");
    n_vec++;
    if (ctl[63:32] !== 32'h00BB00DD) begin
      n_miss++; $display("FAIL misalign_nochange: got %h required 00bb00dd", ctl[63:32]);
    end
    wr(32'h200, 32'h12345678, 4'hF, 1'b1, "stat_wr");
    rd(32'h200, 1'b0, stat_word(0), "stat0_rd");
    rd(32'h21C, 1'b0, stat_word(7), "stat7_rd");
    rd(32'h120, 1'b1, 32'h0, "ctl_oob");
    rd(32'h220, 1'b1, 32'h0, "stat_oob");
    wr(32'h000, 32'h1, 4'hF, 1'b1, "id_wr");
    rd(32'h00C, 1'b1, 32'h0, "unmapped_00c");
    rd(32'h300, 1'b1, 32'h0, "unmapped_300");
`ifdef AXI3_REGBANK_IRQMASK_EN
    wr(32'h008, 32'h00000008, 4'hF, 1'b0, "mask_wr");
    rd(32'h008, 1'b0, 32'h00000008, "mask_rd");
`else
    rd(32'h008, 1'b1, 32'h0, "mask_absent");
`endif
  endtask

  task automatic test_irq;
    irqin[3] = 1'b1;
    @(negedge clk);
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL irq_lag: got %b required 0", irq); end
    @(negedge clk);
    n_vec++; if (irq !== 1'b1) begin n_miss++; $display("FAIL irq_set: got %b required 1", irq); end
    rd(32'h004, 1'b0, 32'h8, "pend_set");
    wr(32'h004, 32'h8, 4'hF, 1'b0, "pend_w1c");
    n_vec++; if (ack_irq !== 1'b1) begin n_miss++; $display("FAIL irq_hold: got %b required 1", ack_irq); end
    n_vec++; if (irq !== 1'b0)     begin n_miss++; $display("FAIL irq_fall: got %b required 0", irq); end
    repeat (3) @(negedge clk);
    rd(32'h004, 1'b0, 32'h0, "pend_noreset");
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL irq_stay_low: got %b required 0", irq); end
  endtask

  task automatic test_set_clear;
    irqin[2] = 1'b1;
    repeat (2) @(negedge clk);
    irqin[2] = 1'b0;
    repeat (2) @(negedge clk);
    bus_start(1'b1, 32'h004, 32'h4, 4'hF, 1'b0, 32'h0, "w1c_vs_edge");
    irqin[2] = 1'b1;
    bus_finish();
    rd(32'h004, 1'b0, 32'h4, "set_wins");
    wr(32'h004, 32'h4, 4'b1110, 1'b0, "w1c_wrong_strb");
    rd(32'h004, 1'b0, 32'h4, "strb_gates_clr");
    wr(32'h004, 32'h4, 4'b0001, 1'b0, "w1c_bit2");
    rd(32'h004, 1'b0, 32'h0, "pend_clear");
    irqin = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int i = 2; i < 6; i++) wr(32'h100 + 32'(4*i), 32'h11111111 * 32'(i), 4'hF, 1'b0, "b2b_wr");
    for (int i = 2; i < 6; i++) rd(32'h100 + 32'(4*i), 1'b0, 32'h11111111 * 32'(i), "b2b_rd");
    n_vec++;
    if (sb.size() != 0) begin n_miss++; $display("FAIL sb_empty: %0d entries left, required 0", sb.size()); end
  endtask

  task automatic test_mid_reset;
    bus_start(1'b1, 32'h100, 32'h1, 4'hF, 1'b0, 32'h0, "midrst_wr");
    @(posedge clk);
    #1;
    n_vec++;
    if (ctl[31:0] !== 32'h1) begin n_miss++; $display("FAIL midrst_commit: got %h required 1", ctl[31:0]); end
    resetn = 1'b0;
    #1;
    n_vec++; if (busack !== 1'b0)    begin n_miss++; $display("FAIL midrst_ack: got %b required 0", busack); end
    n_vec++; if (ctl[31:0] !== 32'h0) begin n_miss++; $display("FAIL midrst_ctl: got %h required 0", ctl[31:0]); end
    sb.delete();
    busreq = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd(32'h100, 1'b0, 32'h0, "ctl0_after_rst");
    rd(32'h104, 1'b0, 32'h0, "ctl1_after_rst");
  endtask

  initial begin
    busaddr  = '0;
    buswdata = '0;
    buswstrb = '0;
    buswr    = 1'b0;
    busreq   = 1'b0;
    irqin    = '0;
    for (int i = 0; i < NSTAT; i++) stat[32*i +: 32] = stat_word(i);
    @(negedge clk);
    test_reset();
    test_ctl_write();
    test_errors();
    test_irq();
    test_set_clear();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
